// File: rtl/sid_bus_pkg.sv
// Shared widths, bank-select address and FIFO entry layout for the SID bus queue.
package sid_bus_pkg;
    localparam int unsigned SID_ADDR_W = 5;
    localparam int unsigned SID_DATA_W = 8;
    localparam int unsigned SID_BANK_W = 2;
    localparam logic [SID_ADDR_W-1:0] SID_BANK_ADDR = 5'h1F;

    typedef struct packed {
        logic [SID_BANK_W-1:0] bank;
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sid_entry_t;

    localparam int unsigned SID_ENTRY_W = $bits(sid_entry_t);

    // Bit 7 of an SPI byte distinguishes a header from a data byte.
    typedef enum logic {
        BYTE_DATA   = 1'b0,
        BYTE_HEADER = 1'b1
    } sid_byte_kind_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/sid_bus_queue.sv
// SPI byte decoder, bank-tagged write queue and CLKEN-paced issue to NUM_SIDS SID instances.
module sid_bus_queue
    import sid_bus_pkg::*;
#(
    parameter int unsigned NUM_SIDS   = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CLK_DIV    = 12
) (
    input  logic                          CLK,
    input  logic                          RESETn,
    input  logic [7:0]                    SPI_DATA,
    input  logic                          SPI_RECV,
    output logic                          CLKEN,
    output logic [NUM_SIDS-1:0]           WR,
    output logic [SID_ADDR_W-1:0]         ADDR,
    output logic [SID_DATA_W-1:0]         DATAW,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          OVERFLOW
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]      div_cnt;
    logic                  issue_slot;
    sid_byte_kind_t        kind;
    logic [SID_ADDR_W-1:0] lat_addr;
    logic [1:0]            lat_hi;
    logic [SID_BANK_W-1:0] bank;
    logic [SID_DATA_W-1:0] wr_byte;
    logic                  data_strobe;
    logic                  bank_cmd;
    logic                  fifo_push;
    sid_entry_t            push_entry;
    sid_entry_t            head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop_ok;
    logic [NUM_SIDS-1:0]   wr_onehot;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            div_cnt <= CNT_LOAD;
        end else if (div_cnt == '0) begin
            div_cnt <= CNT_LOAD;
        end else begin
            div_cnt <= div_cnt - CNT_W'(1);
        end
    end

    assign CLKEN      = (div_cnt == '0);
    // Pop one cycle early so the registered WR lines up with CLKEN.
    assign issue_slot = (div_cnt == CNT_W'(1));

    assign kind        = sid_byte_kind_t'(SPI_DATA[7]);
    assign wr_byte     = {lat_hi, SPI_DATA[5:0]};
    assign data_strobe = SPI_RECV && (kind == BYTE_DATA);
    assign bank_cmd    = data_strobe && (lat_addr == SID_BANK_ADDR);
    assign fifo_push   = data_strobe && !bank_cmd;
    assign push_entry  = '{bank: bank, addr: lat_addr, data: wr_byte};

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            lat_addr <= '0;
            lat_hi   <= '0;
            bank     <= '0;
        end else begin
            if (SPI_RECV && (kind == BYTE_HEADER)) begin
                lat_addr <= SPI_DATA[6:2];
                lat_hi   <= SPI_DATA[1:0];
            end
            if (bank_cmd && (32'(wr_byte[1:0]) < NUM_SIDS)) begin
                bank <= wr_byte[1:0];
            end
        end
    end

    sync_fifo #(
        .WIDTH (SID_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .push    (fifo_push),
        .wr_data (push_entry),
        .pop     (issue_slot),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (LEVEL)
    );

    assign pop_ok = issue_slot && !fifo_empty;

    always_comb begin
        wr_onehot = '0;
        for (int unsigned i = 0; i < NUM_SIDS; i++) begin
            wr_onehot[i] = (32'(head.bank) == i);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            WR       <= '0;
            ADDR     <= '0;
            DATAW    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (pop_ok) begin
                WR    <= wr_onehot;
                ADDR  <= head.addr;
                DATAW <= head.data;
            end else begin
                WR <= '0;
            end
            if (fifo_push && fifo_full && !pop_ok) begin
                OVERFLOW <= 1'b1;
            end
        end
    end
endmodule
